// File: rtl/crc_serial_append_if.sv
// Bit-serial TX link between the packet encoder, the CRC appender and the bit-stuffer.
// The master side drives data/framing/stall; the slave side (the appender) returns the output stream.
interface crc_serial_append_if;
    logic inb;
    logic recving;
    logic start;
    logic pause_out;
    logic outb;
    logic sending;
    logic pause_in;

    modport master (
        output inb, recving, start, pause_out,
        input  outb, sending, pause_in
    );

    modport slave (
        input  inb, recving, start, pause_out,
        output outb, sending, pause_in
    );
endinterface

// File: rtl/crc_serial_append.sv
// Serial CRC generator/appender: passes data through, then appends the inverted CRC MSB first.
// Optional receive-side residue checking is built when CRC_CHECK_EN is defined. CRC_W legal range is 2..32.
module crc_serial_append #(
    parameter int unsigned      CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY  = 5'h05,
    parameter logic [CRC_W-1:0] INIT  = {CRC_W{1'b1}}
`ifdef CRC_CHECK_EN
    ,parameter logic [CRC_W-1:0] RESIDUE = 5'h0C
`endif
) (
    input  logic clk,
    input  logic rst,
`ifdef CRC_CHECK_EN
    input  logic check_mode,
    output logic crc_valid,
    output logic crc_ok,
`endif
    crc_serial_append_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(CRC_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [CRC_W-1:0] crc_r, crc_next_s, crc_shift_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s, bit_idx_s;
    logic             outb_s, sending_s, pause_in_s;
`ifdef CRC_CHECK_EN
    logic             check_r, check_next_s;
    logic             valid_r, valid_next_s;
    logic             ok_r, ok_next_s;
`endif

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

    assign crc_shift_s = crc_step(crc_r, bus.inb);
    assign bit_idx_s   = CNT_MAX - cnt_r;

    // Next-state, CRC/counter update and combinational stream outputs.
    always_comb begin
        state_next_s = state_r;
        crc_next_s   = crc_r;
        cnt_next_s   = cnt_r;
        outb_s       = 1'b0;
        sending_s    = 1'b0;
        pause_in_s   = 1'b0;
`ifdef CRC_CHECK_EN
        check_next_s = check_r;
        valid_next_s = 1'b0;
        ok_next_s    = ok_r;
`endif
        case (state_r)
            S_IDLE: begin
                crc_next_s = INIT;
                if (bus.recving) begin
                    outb_s    = bus.inb;
                    sending_s = 1'b1;
                    if (bus.start) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_CALC;
`ifdef CRC_CHECK_EN
                        check_next_s = check_mode;
`endif
                        if (!bus.pause_out) begin
                            crc_next_s = crc_shift_s;
                        end else begin
                            crc_next_s = INIT;
                        end
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.recving) begin
                    outb_s    = bus.inb;
                    sending_s = 1'b1;
                    if (!bus.pause_out) begin
                        crc_next_s = crc_shift_s;
                    end else begin
                        crc_next_s = crc_r;
                    end
                end
`ifdef CRC_CHECK_EN
                else if (check_r) begin
                    // Check mode: the trailing CRC field was shifted in, so crc_r now holds the residue.
                    valid_next_s = 1'b1;
                    ok_next_s    = (crc_r == RESIDUE);
                    check_next_s = 1'b0;
                    crc_next_s   = INIT;
                    state_next_s = S_IDLE;
                end
`endif
                else begin
                    // First CRC bit goes out in the same cycle recving drops, leaving no gap.
                    outb_s       = ~crc_r[bit_idx_s];
                    sending_s    = 1'b1;
                    pause_in_s   = 1'b1;
                    state_next_s = S_SEND;
                    if (!bus.pause_out) begin
                        cnt_next_s = cnt_r + CNT_W'(1'b1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
            end
            S_SEND: begin
                outb_s     = ~crc_r[bit_idx_s];
                sending_s  = 1'b1;
                pause_in_s = 1'b1;
                if (!bus.pause_out) begin
                    if (cnt_r == CNT_MAX) begin
                        cnt_next_s   = {CNT_W{1'b0}};
                        crc_next_s   = INIT;
                        state_next_s = S_IDLE;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(1'b1);
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                crc_next_s   = INIT;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, CRC and bit-count registers; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            crc_r   <= INIT;
            cnt_r   <= {CNT_W{1'b0}};
`ifdef CRC_CHECK_EN
            check_r <= 1'b0;
            valid_r <= 1'b0;
            ok_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            crc_r   <= crc_next_s;
            cnt_r   <= cnt_next_s;
`ifdef CRC_CHECK_EN
            check_r <= check_next_s;
            valid_r <= valid_next_s;
            ok_r    <= ok_next_s;
`endif
        end
    end

    assign bus.outb     = outb_s;
    assign bus.sending  = sending_s;
    assign bus.pause_in = pause_in_s;
`ifdef CRC_CHECK_EN
    assign crc_valid    = valid_r;
    assign crc_ok       = ok_r;
`endif
endmodule

// File: tb/tb_crc_serial_append.sv
// Directed bench for crc_serial_append in its default CRC5 build; the check-mode step
// is included when CRC_CHECK_EN is defined.
module tb_crc_serial_append;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
`ifdef CRC_CHECK_EN
    logic       check_mode = 1'b0;
    logic       crc_valid;
    logic       crc_ok;
    logic [5:0] pkt;
`endif

    crc_serial_append_if bus();

    crc_serial_append dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CRC_CHECK_EN
        .check_mode (check_mode),
        .crc_valid  (crc_valid),
        .crc_ok     (crc_ok),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic b, input logic p);
        bus.recving   = r;
        bus.start     = s;
        bus.inb       = b;
        bus.pause_out = p;
        #2;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drives the CRC field phase (recving low), stalling on cycles flagged in stall,
    // and checks each output bit, the cycle count and the return to idle.
    task automatic expect_crc(input string tag, input logic [4:0] exp_bits,
                              input logic [7:0] stall, input int exp_cycles);
        int   k = 0;
        int   c = 0;
        logic st;
        while (k < 5 && c < 12) begin
            st = (c < 8) ? stall[c[2:0]] : 1'b0;
            set_in(1'b0, 1'b0, 1'b0, st);
            check_bit({tag, "_bit"}, bus.outb, exp_bits[4-k]);
            check_bit({tag, "_pause_in"}, bus.pause_in, 1'b1);
            tick();
            if (!st) k++;
            c++;
        end
        check_int({tag, "_cycles"}, c, exp_cycles);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check_bit({tag, "_idle_sending"}, bus.sending, 1'b0);
        check_bit({tag, "_idle_pause_in"}, bus.pause_in, 1'b0);
        check_bit({tag, "_idle_outb"}, bus.outb, 1'b0);
        tick();
    endtask

    logic [7:0] hdr;

    initial begin
        bus.inb = 1'b0; bus.recving = 1'b0; bus.start = 1'b0; bus.pause_out = 1'b0;
        tick();
        tick();
        check_bit("rst_outb", bus.outb, 1'b0);
        check_bit("rst_sending", bus.sending, 1'b0);
        check_bit("rst_pause_in", bus.pause_in, 1'b0);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Test 1: payload 0 -> crc 11011, inverted field 00100
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("t1_data_outb", bus.outb, 1'b0);
        check_bit("t1_data_sending", bus.sending, 1'b1);
        check_bit("t1_data_pause_in", bus.pause_in, 1'b0);
        tick();
        expect_crc("t1", 5'b00100, 8'b0000_0000, 5);

        // Test 2: payload 1 -> crc 11110, field 00001
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        check_bit("t2_data_outb", bus.outb, 1'b1);
        tick();
        expect_crc("t2", 5'b00001, 8'b0000_0000, 5);

        // Test 3: test 1 with stalls on the 2nd and 4th CRC cycles
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_crc("t3", 5'b00100, 8'b0000_1010, 7);

        // Test 4: 8 header bits bypass the CRC, then payload 0
        hdr = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            set_in(1'b1, 1'b1, hdr[i], 1'b0);
            check_bit("t4_hdr_outb", bus.outb, hdr[i]);
            check_bit("t4_hdr_sending", bus.sending, 1'b1);
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_crc("t4", 5'b00100, 8'b0000_0000, 5);

        // Two-bit payload 1,0 -> crc 11001, field 00110
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("p2_data_outb", bus.outb, 1'b0);
        tick();
        expect_crc("p2", 5'b00110, 8'b0000_0000, 5);

        // Stalled first data bit is not shifted: 0(stalled),1 -> same as payload 1
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_crc("stl", 5'b00001, 8'b0000_0000, 5);

        // Test 5: reset during the 3rd CRC bit, then a clean packet
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("t5_bit0", bus.outb, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("t5_bit1", bus.outb, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("t5_bit2", bus.outb, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("t5_abort_outb", bus.outb, 1'b0);
        check_bit("t5_abort_sending", bus.sending, 1'b0);
        check_bit("t5_abort_pause_in", bus.pause_in, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_crc("t5_next", 5'b00001, 8'b0000_0000, 5);

`ifdef CRC_CHECK_EN
        // Test 6: payload 0 plus its CRC field gives the good residue; a flipped bit does not
        pkt = 6'b000100;
        check_mode = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            set_in(1'b1, 1'b0, pkt[i], 1'b0);
            tick();
            check_mode = 1'b0;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("t6_no_pause_in", bus.pause_in, 1'b0);
        tick();
        check_bit("t6_valid", crc_valid, 1'b1);
        check_bit("t6_ok", crc_ok, 1'b1);
        tick();
        check_bit("t6_valid_pulse", crc_valid, 1'b0);
        pkt = 6'b000101;
        check_mode = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            set_in(1'b1, 1'b0, pkt[i], 1'b0);
            tick();
            check_mode = 1'b0;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_bit("t6_bad_valid", crc_valid, 1'b1);
        check_bit("t6_bad_ok", crc_ok, 1'b0);
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
